// File: rtl/mdio_pkg.sv
// mdio_pkg: shared frame states and field codes for the clause-22 MDIO responder
`timescale 1ns/1ps
package mdio_pkg;
  typedef enum logic [2:0] {IDLE, ST2, OP, ADDR, TA, RDATA, WDATA, SKIP} state_t;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] ST_CODE = 2'b01;
  localparam int FRAME_DATA_BITS = 16;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser bringing an asynchronous level into the CLK domain
`timescale 1ns/1ps
module sync_2ff (
  input  logic CLK,
  input  logic RST,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  always_ff @(posedge CLK or posedge RST)
    if (RST) {o_q, r_meta} <= 2'b00;
    else {o_q, r_meta} <= {r_meta, i_d};
endmodule

// File: rtl/mdio_responder.sv
// mdio_responder: clause-22 MDIO slave serving a 32 x 16-bit register file via rd/wr strobes
`timescale 1ns/1ps
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd0,
  parameter int PREAMBLE_MIN = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic [4:0]  reg_addr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        reg_wr,
  output logic [15:0] reg_wdata,
  output logic        busy
);
  localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);
  localparam logic [1:0] RD_IDX = 2'(RD_LATENCY - 1);
  localparam logic [4:0] LAST_BIT = 5'(FRAME_DATA_BITS - 1);
  logic w_mdc, w_mdio, w_sedge, w_op_ok;
  logic [15:0] w_sr_in;
  logic r_mdc_q, r_is_rd;
  logic [5:0] r_pre;
  logic [4:0] r_cnt;
  logic [15:0] r_sr;
  logic [3:0] r_rd_pipe;
  state_t r_state;
  sync_2ff u_sync_mdc (.CLK(CLK), .RST(RST), .i_d(mdc), .o_q(w_mdc));
  sync_2ff u_sync_mdio (.CLK(CLK), .RST(RST), .i_d(mdio_i), .o_q(w_mdio));
  assign w_sedge = w_mdc & ~r_mdc_q;
  assign w_sr_in = {r_sr[14:0], w_mdio};
  assign w_op_ok = (w_sr_in[1:0] == OP_READ) || (w_sr_in[1:0] == OP_WRITE);
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_mdc_q <= 1'b0;
      r_is_rd <= 1'b0;
      r_pre <= '0;
      r_cnt <= '0;
      r_sr <= '0;
      r_rd_pipe <= '0;
      mdio_o <= 1'b1;
      mdio_oe <= 1'b0;
      reg_addr <= '0;
      reg_rd <= 1'b0;
      reg_wr <= 1'b0;
      reg_wdata <= '0;
      busy <= 1'b0;
    end else begin
      r_mdc_q <= w_mdc;
      reg_rd <= 1'b0;
      reg_wr <= 1'b0;
      r_rd_pipe <= {r_rd_pipe[2:0], reg_rd};
      if (r_rd_pipe[RD_IDX]) r_sr <= reg_rdata;
      if (w_sedge) begin
        case (r_state)
          IDLE: begin
            r_pre <= w_mdio ? ((r_pre == 6'd32) ? r_pre : r_pre + 6'd1) : '0;
            if (!w_mdio && r_pre >= PRE_MIN) begin
              r_state <= ST2;
              busy <= 1'b1;
            end
          end
          ST2: begin
            r_cnt <= '0;
            r_state <= (w_mdio == ST_CODE[0]) ? OP : IDLE;
            busy <= (w_mdio == ST_CODE[0]);
          end
          OP: begin
            r_sr <= w_sr_in;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd1) begin
              r_cnt <= '0;
              r_is_rd <= (w_sr_in[1:0] == OP_READ);
              r_state <= w_op_ok ? ADDR : IDLE;
              busy <= w_op_ok;
            end
          end
          ADDR: begin
            r_sr <= w_sr_in;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd9) begin
              r_cnt <= '0;
              if (w_sr_in[9:5] != PHY_ADDR) r_state <= SKIP;
              else begin
                reg_addr <= w_sr_in[4:0];
                reg_rd <= r_is_rd;
                r_state <= TA;
              end
            end
          end
          TA: begin
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd0) begin
              mdio_oe <= r_is_rd;
              mdio_o <= ~r_is_rd;
            end else begin
              r_cnt <= '0;
              r_state <= r_is_rd ? RDATA : WDATA;
              mdio_o <= r_is_rd ? r_sr[15] : 1'b1;
              r_sr <= {r_sr[14:0], 1'b0};
            end
          end
          RDATA: begin
            r_cnt <= r_cnt + 5'd1;
            r_sr <= {r_sr[14:0], 1'b0};
            mdio_o <= r_sr[15];
            if (r_cnt == LAST_BIT) begin
              mdio_o <= 1'b1;
              mdio_oe <= 1'b0;
              busy <= 1'b0;
              r_state <= IDLE;
            end
          end
          WDATA: begin
            r_sr <= w_sr_in;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == LAST_BIT) begin
              reg_wr <= 1'b1;
              reg_wdata <= w_sr_in;
              busy <= 1'b0;
              r_state <= IDLE;
            end
          end
          SKIP: begin
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd17) begin
              busy <= 1'b0;
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: random and directed MDIO frames against a register-file model with a strobe scoreboard
`timescale 1ns/1ps
module tb_mdio_responder;
  localparam int RDL = 2;
  logic CLK = 1'b0, RST = 1'b1, mdc = 1'b0, mdio_i = 1'b1;
  logic mdio_o, mdio_oe, reg_rd, reg_wr, busy;
  logic [4:0] reg_addr;
  logic [15:0] reg_rdata, reg_wdata;

  mdio_responder #(.PHY_ADDR(5'd0), .PREAMBLE_MIN(32), .RD_LATENCY(RDL)) dut (
    .CLK(CLK), .RST(RST), .mdc(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o), .mdio_oe(mdio_oe),
    .reg_addr(reg_addr), .reg_rd(reg_rd), .reg_rdata(reg_rdata), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .busy(busy)
  );

  always #15 CLK = ~CLK;

  typedef struct {bit wr; logic [4:0] addr; logic [15:0] data;} exp_t;
  exp_t exp_q[$];
  int n_cmp = 0, n_err = 0, oe_cnt;
  bit busy_seen;
  logic last_o;
  logic [15:0] seed [32], wval [32], model [32];
  bit written [32];
  logic [3:0] rd_pipe = '0;

  // Register file behind the strobes: data is valid only exactly RDL cycles after reg_rd.
  assign reg_rdata = rd_pipe[RDL-1] ? (written[reg_addr] ? wval[reg_addr] : seed[reg_addr]) : 16'hdead;
  always @(posedge CLK) begin
    rd_pipe <= {rd_pipe[2:0], reg_rd};
    if (reg_wr) begin
      wval[reg_addr] <= reg_wdata;
      written[reg_addr] <= 1'b1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      if (busy) busy_seen = 1'b1;
      if (reg_rd || reg_wr) begin
        check("strobe_excl", {31'b0, reg_rd & reg_wr}, 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_strobe rd=%0b wr=%0b addr=%0d", reg_rd, reg_wr, reg_addr);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", {31'b0, reg_wr}, {31'b0, e.wr});
          check("strobe_addr", {27'b0, reg_addr}, {27'b0, e.addr});
          if (e.wr) check("wdata", {16'b0, reg_wdata}, {16'b0, e.data});
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    mdio_i = b;
    #200 mdc = 1'b1;
    last_o = mdio_o;
    if (mdio_oe) oe_cnt++;
    #200 mdc = 1'b0;
  endtask

  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [15:0] wd, input int rst_at);
    bit acc, rd, wr, hit, aborted;
    logic [15:0] rdv;
    logic ta2;
    acc = (pre >= 32);
    rd = (op == 2'b10);
    wr = (op == 2'b01);
    hit = acc && (rd || wr) && (phy == 5'd0);
    if (hit) exp_q.push_back('{wr, ra, wd});
    if (hit && wr) model[ra] = wd;
    busy_seen = 1'b0;
    oe_cnt = 0;
    aborted = 1'b0;
    rdv = '0;
    ta2 = 1'b1;
    send_bit(1'b0);
    repeat (pre) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(op[1]);
    send_bit(op[0]);
    if (rd || wr) begin
      for (int i = 4; i >= 0; i--) send_bit(phy[i]);
      for (int i = 4; i >= 0; i--) send_bit(ra[i]);
      if (wr) begin
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 15; i >= 0; i--) send_bit(wd[i]);
      end else begin
        for (int i = 0; i < 18 && !aborted; i++) begin
          if (i == rst_at) begin
            mdio_i = 1'b1;
            #200 mdc = 1'b1;
            #150 RST = 1'b1;
            #1 check("oe_on_reset", {31'b0, mdio_oe}, 32'd0);
            check("busy_on_reset", {31'b0, busy}, 32'd0);
            #49 mdc = 1'b0;
            #100 RST = 1'b0;
            aborted = 1'b1;
          end else begin
            send_bit(1'b1);
            if (i == 1) ta2 = last_o;
            if (i >= 2) rdv = {rdv[14:0], last_o};
          end
        end
      end
    end
    #400;
    if (!aborted) begin
      check("busy_end", {31'b0, busy}, 32'd0);
      check("busy_seen", {31'b0, busy_seen}, {31'b0, acc});
      check("oe_periods", oe_cnt, (hit && rd) ? 32'd17 : 32'd0);
      if (hit && rd) begin
        check("ta2_zero", {31'b0, ta2}, 32'd0);
        check("rdata", {16'b0, rdv}, {16'b0, model[ra]});
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, pre;
    logic [1:0] op;
    logic [4:0] phy;
    for (int i = 0; i < 32; i++) begin
      seed[i] = 16'($urandom);
      model[i] = seed[i];
    end
    seed[2] = 16'h0141;
    model[2] = 16'h0141;
    repeat (5) @(posedge CLK);
    #3;
    check("rst_mdio_o", {31'b0, mdio_o}, 32'd1);
    check("rst_mdio_oe", {31'b0, mdio_oe}, 32'd0);
    check("rst_reg_rd", {31'b0, reg_rd}, 32'd0);
    check("rst_reg_wr", {31'b0, reg_wr}, 32'd0);
    check("rst_reg_addr", {27'b0, reg_addr}, 32'd0);
    check("rst_reg_wdata", {16'b0, reg_wdata}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    RST = 1'b0;
    #100;
    frame(32, 2'b10, 5'd0, 5'd2, 16'h0, -1);
    frame(32, 2'b01, 5'd0, 5'd0, 16'h9140, -1);
    frame(32, 2'b10, 5'd3, 5'd2, 16'h0, -1);
    frame(32, 2'b10, 5'd0, 5'd2, 16'h0, -1);
    frame(20, 2'b10, 5'd0, 5'd5, 16'h0, -1);
    frame(20, 2'b01, 5'd0, 5'd5, 16'h1234, -1);
    frame(32, 2'b11, 5'd0, 5'd1, 16'h0, -1);
    frame(32, 2'b10, 5'd0, 5'd0, 16'h0, -1);
    frame(32, 2'b10, 5'd0, 5'd2, 16'h0, 9);
    frame(32, 2'b10, 5'd0, 5'd2, 16'h0, -1);
    for (int k = 0; k < 14; k++) begin
      pre = ($urandom % 5 == 0) ? int'($urandom_range(8, 31)) : int'($urandom_range(32, 35));
      r = int'($urandom % 6);
      op = (r < 3) ? 2'b10 : (r < 5) ? 2'b01 : (($urandom % 2) != 0 ? 2'b11 : 2'b00);
      phy = ($urandom % 5 == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      frame(pre, op, phy, 5'($urandom), 16'($urandom), -1);
    end
    #1000;
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
